// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared state enum, default widths and init-pattern helper for mem_seq_ctrl
package mem_seq_pkg;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {IDLE, INIT, READY} state_t;

    // {a, ~a} over aw bits each; the caller truncates or zero-extends to its data width
    function automatic logic [63:0] init_pat(input logic [31:0] a, input int aw);
        logic [63:0] m;
        m = (64'd1 << aw) - 64'd1;
        return ({32'd0, a} << aw) | (~{32'd0, a} & m);
    endfunction
endpackage

// File: rtl/scan_tick.sv
// scan_tick: one-cycle tick every SCAN_DIV enabled cycles; count clears whenever disabled
module scan_tick #(
    parameter int SCAN_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && cnt == CW'(SCAN_DIV - 1);

    // divider count, restarted on every tick and held at zero while disabled
    always_ff @(posedge clk)
        if (rst || !en || tick) cnt <= '0;
        else cnt <= cnt + CW'(1);
endmodule

// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl: memory init sequencer and user-write arbiter; MEM_SEQ_SCAN_EN enables read-address scanning
module mem_seq_ctrl
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int SCAN_DIV = 25000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_sel,
    output logic              wr_ack,
    output logic              busy,
    output logic              init_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_din,
    output logic [ADDR_W-1:0] mem_raddr
);
    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n, waddr_n, raddr_n;
    logic [DATA_W-1:0] din_n;
    logic              we_n, ack_n, busy_n, done_n;

    // state, init counter and all outputs are registered from their next values
    always_ff @(posedge clk)
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_we    <= 1'b0;
            wr_ack    <= 1'b0;
            busy      <= 1'b0;
            init_done <= 1'b0;
            mem_waddr <= '0;
            mem_din   <= '0;
            mem_raddr <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            mem_we    <= we_n;
            wr_ack    <= ack_n;
            busy      <= busy_n;
            init_done <= done_n;
            mem_waddr <= waddr_n;
            mem_din   <= din_n;
            mem_raddr <= raddr_n;
        end

    // next state plus next outputs; an accepted write is blocked while its ack is showing
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        we_n    = 1'b0;
        ack_n   = 1'b0;
        busy_n  = 1'b0;
        done_n  = init_done;
        waddr_n = '0;
        din_n   = '0;
        case (state)
            IDLE:
                if (start) begin
                    state_n = INIT;
                    cnt_n   = '0;
                end
            INIT:
                if (cnt == LAST) begin
                    state_n = READY;
                    done_n  = 1'b1;
                end else cnt_n = cnt + 1'b1;
            READY:
                if (start) begin
                    state_n = INIT;
                    cnt_n   = '0;
                end else if (wr_req && !wr_ack) begin
                    we_n    = 1'b1;
                    ack_n   = 1'b1;
                    waddr_n = wr_addr;
                    din_n   = wr_data;
                end
            default: state_n = IDLE;
        endcase
        if (state_n == INIT) begin
            we_n    = 1'b1;
            busy_n  = 1'b1;
            waddr_n = cnt_n;
            din_n   = DATA_W'(init_pat(32'(cnt_n), ADDR_W));
        end
    end

`ifdef MEM_SEQ_SCAN_EN
    logic tick;

    scan_tick #(.SCAN_DIV(SCAN_DIV)) u_scan_tick (
        .clk (clk),
        .rst (rst),
        .en  (state == READY),
        .tick(tick)
    );

    assign raddr_n = state_n != READY ? '0 : mem_raddr + ADDR_W'(tick);
`else
    assign raddr_n = state_n == READY ? rd_sel : '0;
`endif
endmodule
